hazard_unit_sb: RTL
===================

Name: hazard_unit_sb

Overview:
Next-generation hazard unit for the RV32I 5-stage pipeline. It adds the following on top of combinational M/W forwarding, load-use stall and branch flush:
- a register scoreboard for a variable-latency multiply/divide unit (MDU);
- data-memory wait-state stalls;
- saturating stall/flush performance counters.

It sits beside the datapath and drives all stall, flush and forward-select controls.

Parameters:
REG_AW, 5, register address width; scoreboard depth = 2**REG_AW.
CNT_W, 16, performance counter width.
FWD_W, 2, forward-select width (00 regfile, 01 W, 10 M).

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_rs1_addrD / i_rs2_addrD  in  REG_AW  decode source registers
i_rs1_usedD / i_rs2_usedD  in  1  decode instruction actually reads rs1/rs2
i_rd_addrD  in  REG_AW  decode destination
i_mdu_opD  in  1  decode instruction is an MDU op
i_rs1_addrE / i_rs2_addrE / i_rd_addrE  in  REG_AW  execute-stage registers
i_is_loadE  in  1  E instruction is a load
i_mdu_startE  in  1  E issues an MDU op writing i_rd_addrE
i_PCSrcE  in  1  taken branch/jump resolved in E
i_rd_addrM / i_rd_addrW  in  REG_AW  destinations in M and W
i_reg_wr_enM / i_reg_wr_enW  in  1  write enables in M and W
i_dmem_waitM  in  1  data memory not ready; M must hold
i_mdu_done  in  1  MDU result written to regfile this cycle
i_mdu_rd  in  REG_AW  destination of the completing MDU op
o_forwardAE / o_forwardBE  out  FWD_W  ALU operand select
o_stallF / o_stallD / o_stallE / o_stallM  out  1  hold stage register
o_flushD / o_flushE / o_flushW  out  1  insert bubble
o_mdu_busy  out  1  MDU op outstanding
o_stall_cnt / o_flush_cnt  out  CNT_W  performance counters

Behaviour:
- Reset (async): scoreboard = 0, busy = 0, both counters = 0. Combinational outputs then reflect inputs with an empty scoreboard.
- Forwarding:
  - M has priority over W.
  - Forwarding requires a matching address, the stage write enable set, and rs != 0.
  - Both selects are 00 when o_stallE = 1.
- memStall = i_dmem_waitM.
- ldStall = i_is_loadE && rd_addrE != 0 && ((rs1D == rdE && rs1_usedD) || (rs2D == rdE && rs2_usedD)).
- sbStall = scoreboard hit on a used rs1D/rs2D or on rdD (WAW, rdD != 0).
- mduStall = i_mdu_opD && o_mdu_busy.
- decStall = ldStall | sbStall | mduStall.
- Priority when memStall = 1:
  - stallF, stallD, stallE, stallM = 1; flushW = 1.
  - flushD = flushE = 0, even if i_PCSrcE (branch is held and re-evaluated).
  - No scoreboard set.
- When memStall = 0:
  - stallF = stallD = decStall & !i_PCSrcE.
  - flushE = decStall | i_PCSrcE.
  - flushD = i_PCSrcE; branch flush overrides decode stall because the D instruction is wrong-path.
  - stallE = stallM = flushW = 0.
- Scoreboard (1 bit per register, bit 0 hardwired 0). At the clock edge:
  - set bit[rdE] when i_mdu_startE && !o_stallE && rdE != 0;
  - clear bit[i_mdu_rd] when i_mdu_done;
  - set wins over clear for the same index.
- Busy:
  - set on an accepted start;
  - cleared on i_mdu_done;
  - start and done in the same cycle leaves busy = 1.
  - Only one MDU op is outstanding; a start while busy cannot occur because of mduStall.
- Stall release: a scoreboard stall is still asserted in the i_mdu_done cycle and releases the next cycle (result is in the regfile by then).
- Counters:
  - o_stall_cnt += 1 each cycle o_stallF = 1.
  - o_flush_cnt += 1 each cycle o_flushD | o_flushE.
  - Both saturate at 2**CNT_W - 1.
  - Both are registered and reset to 0.
- Latency: all control outputs are combinational, same cycle. Scoreboard, busy and counters update one cycle after their cause.

Decomposition:
- Package hazard_pkg holds:
  - FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - default REG_AW and CNT_W.
- Optional sub-module hazard_scoreboard: the set/clear bit vector with busy flag and hit lookup for three addresses.
- Forwarding, stall priority and counters stay in the top module.

Test Plan:
- Forwarding:
  - rs1E=5, rdM=5, wr_enM=1, rdW=5, wr_enW=1 -> forwardAE=10.
  - rs2E=0 with rdM=0 -> forwardBE=00.
- Load-use:
  - load rdE=7, rs2D=7, rs2_usedD=1 -> stallF=stallD=flushE=1 for exactly one cycle, stall_cnt=1.
  - Same with rs2_usedD=0 -> no stall.
- MDU RAW:
  - accepted start rd=9, then D reads x9 -> stall held until the cycle after i_mdu_done (rd=9);
  - scoreboard clear, busy=0.
  - done and a new start to rd=9 in the same cycle -> bit 9 stays set.
- dmem wait with branch:
  - i_dmem_waitM=1 and i_PCSrcE=1 for 3 cycles -> stallF..M=1, flushW=1, flushD=flushE=0;
  - on release -> flushD=flushE=1.
- Branch over decode stall: ldStall and i_PCSrcE together -> flushD=flushE=1, stallF=0.
- Reset and saturation:
  - async i_rst mid-MDU op -> scoreboard, busy and counters 0 immediately.
  - CNT_W=4 with 20 stall cycles -> o_stall_cnt=15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the RV32I hazard unit: forward-select encodings and default widths.
package hazard_pkg;

  localparam int DEF_REG_AW = 5;
  localparam int DEF_CNT_W  = 16;

  typedef logic [1:0] fwd_t;

  localparam fwd_t FWD_REG = 2'b00;
  localparam fwd_t FWD_W   = 2'b01;
  localparam fwd_t FWD_M   = 2'b10;

endpackage

// File: rtl/hazard_unit_sb_if.sv
// Datapath <-> hazard unit signal bundle; master = datapath side, slave = hazard unit.
interface hazard_unit_sb_if
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = DEF_CNT_W
) ();

  logic [REG_AW-1:0] i_rs1_addrD;
  logic [REG_AW-1:0] i_rs2_addrD;
  logic              i_rs1_usedD;
  logic              i_rs2_usedD;
  logic [REG_AW-1:0] i_rd_addrD;
  logic              i_mdu_opD;
  logic [REG_AW-1:0] i_rs1_addrE;
  logic [REG_AW-1:0] i_rs2_addrE;
  logic [REG_AW-1:0] i_rd_addrE;
  logic              i_is_loadE;
  logic              i_mdu_startE;
  logic              i_PCSrcE;
  logic [REG_AW-1:0] i_rd_addrM;
  logic [REG_AW-1:0] i_rd_addrW;
  logic              i_reg_wr_enM;
  logic              i_reg_wr_enW;
  logic              i_dmem_waitM;
  logic              i_mdu_done;
  logic [REG_AW-1:0] i_mdu_rd;

  fwd_t              o_forwardAE;
  fwd_t              o_forwardBE;
  logic              o_stallF;
  logic              o_stallD;
  logic              o_stallE;
  logic              o_stallM;
  logic              o_flushD;
  logic              o_flushE;
  logic              o_flushW;
  logic              o_mdu_busy;
  logic [CNT_W-1:0]  o_stall_cnt;
  logic [CNT_W-1:0]  o_flush_cnt;

  modport master (
    output i_rs1_addrD, i_rs2_addrD, i_rs1_usedD, i_rs2_usedD, i_rd_addrD, i_mdu_opD,
           i_rs1_addrE, i_rs2_addrE, i_rd_addrE, i_is_loadE, i_mdu_startE, i_PCSrcE,
           i_rd_addrM, i_rd_addrW, i_reg_wr_enM, i_reg_wr_enW, i_dmem_waitM,
           i_mdu_done, i_mdu_rd,
    input  o_forwardAE, o_forwardBE, o_stallF, o_stallD, o_stallE, o_stallM,
           o_flushD, o_flushE, o_flushW, o_mdu_busy, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_rs1_addrD, i_rs2_addrD, i_rs1_usedD, i_rs2_usedD, i_rd_addrD, i_mdu_opD,
           i_rs1_addrE, i_rs2_addrE, i_rd_addrE, i_is_loadE, i_mdu_startE, i_PCSrcE,
           i_rd_addrM, i_rd_addrW, i_reg_wr_enM, i_reg_wr_enW, i_dmem_waitM,
           i_mdu_done, i_mdu_rd,
    output o_forwardAE, o_forwardBE, o_stallF, o_stallD, o_stallE, o_stallM,
           o_flushD, o_flushE, o_flushW, o_mdu_busy, o_stall_cnt, o_flush_cnt
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard for the MDU: one bit per register plus an outstanding-op flag.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startEn,
  input  logic [REG_AW-1:0] setIdx,
  input  logic              clrEn,
  input  logic [REG_AW-1:0] clrIdx,
  input  logic [REG_AW-1:0] addrA,
  input  logic [REG_AW-1:0] addrB,
  input  logic [REG_AW-1:0] addrC,
  output logic              hitA,
  output logic              hitB,
  output logic              hitC,
  output logic              busy
);

  localparam int DEPTH = 2 ** REG_AW;

  logic [DEPTH-1:0] sbQ;
  logic [DEPTH-1:0] sbNext;

  // Set is applied after clear so a same-cycle restart of the same register keeps it pending.
  always_comb begin
    sbNext = sbQ;
    if (clrEn) sbNext[clrIdx] = 1'b0;
    if (startEn && setIdx != '0) sbNext[setIdx] = 1'b1;
    sbNext[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbQ  <= '0;
      busy <= 1'b0;
    end else begin
      sbQ <= sbNext;
      if (startEn)    busy <= 1'b1;
      else if (clrEn) busy <= 1'b0;
    end
  end

  assign hitA = sbQ[addrA];
  assign hitB = sbQ[addrB];
  assign hitC = sbQ[addrC];

endmodule

// File: rtl/hazard_unit_sb.sv
// Pipeline hazard unit: M/W forwarding, load-use / scoreboard / MDU / dmem-wait stalls, flushes, perf counters.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic           i_clk,
  input  logic           i_rst,
  hazard_unit_sb_if.slave hz
);

  logic memStall, ldStall, sbStall, mduStall, decStall;
  logic hitRs1, hitRs2, hitRd;
  logic mduBusy, mduAccept;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  function automatic fwd_t fwdSel(input logic [REG_AW-1:0] rs,
                                  input logic [REG_AW-1:0] rdM, input logic wrM,
                                  input logic [REG_AW-1:0] rdW, input logic wrW);
    fwd_t sel;
    sel = FWD_REG;
    if (rs != '0) begin
      if (wrM && rdM == rs)      sel = FWD_M;
      else if (wrW && rdW == rs) sel = FWD_W;
    end
    return sel;
  endfunction

  assign memStall  = hz.i_dmem_waitM;
  assign mduAccept = hz.i_mdu_startE && !memStall;

  hazard_scoreboard #(.REG_AW(REG_AW)) uSb (
    .clk    (i_clk),
    .rst    (i_rst),
    .startEn(mduAccept),
    .setIdx (hz.i_rd_addrE),
    .clrEn  (hz.i_mdu_done),
    .clrIdx (hz.i_mdu_rd),
    .addrA  (hz.i_rs1_addrD),
    .addrB  (hz.i_rs2_addrD),
    .addrC  (hz.i_rd_addrD),
    .hitA   (hitRs1),
    .hitB   (hitRs2),
    .hitC   (hitRd),
    .busy   (mduBusy)
  );

  assign ldStall  = hz.i_is_loadE && (hz.i_rd_addrE != '0) &&
                    ((hz.i_rs1_addrD == hz.i_rd_addrE && hz.i_rs1_usedD) ||
                     (hz.i_rs2_addrD == hz.i_rd_addrE && hz.i_rs2_usedD));
  assign sbStall  = (hitRs1 && hz.i_rs1_usedD) || (hitRs2 && hz.i_rs2_usedD) ||
                    (hitRd && hz.i_rd_addrD != '0);
  assign mduStall = hz.i_mdu_opD && mduBusy;
  assign decStall = ldStall | sbStall | mduStall;

  // A dmem wait freezes the whole front end, so a resolved branch is held and re-evaluated later.
  assign hz.o_stallF = memStall | (decStall & !hz.i_PCSrcE);
  assign hz.o_stallD = memStall | (decStall & !hz.i_PCSrcE);
  assign hz.o_stallE = memStall;
  assign hz.o_stallM = memStall;
  assign hz.o_flushW = memStall;
  assign hz.o_flushD = !memStall & hz.i_PCSrcE;
  assign hz.o_flushE = !memStall & (decStall | hz.i_PCSrcE);

  assign hz.o_forwardAE = memStall ? FWD_REG :
                          fwdSel(hz.i_rs1_addrE, hz.i_rd_addrM, hz.i_reg_wr_enM,
                                 hz.i_rd_addrW, hz.i_reg_wr_enW);
  assign hz.o_forwardBE = memStall ? FWD_REG :
                          fwdSel(hz.i_rs2_addrE, hz.i_rd_addrM, hz.i_reg_wr_enM,
                                 hz.i_rd_addrW, hz.i_reg_wr_enW);

  assign hz.o_mdu_busy = mduBusy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (hz.o_stallF && stallCnt != '1)                 stallCnt <= stallCnt + 1'b1;
      if ((hz.o_flushD || hz.o_flushE) && flushCnt != '1) flushCnt <= flushCnt + 1'b1;
    end
  end

  assign hz.o_stall_cnt = stallCnt;
  assign hz.o_flush_cnt = flushCnt;

endmodule
